// File: rtl/interval_sched_pkg.sv
// Shared definitions for the interval scheduler: FSM encoding, default counter
// width and requester indices.
package interval_sched_pkg;

  localparam int CNT_W_DEFAULT = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [1:0] req_onehot(input logic idx);
    return (idx == REQ1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/interval_counter.sv
// Shared up-counter datapath; a synchronous clear takes priority over enable.
module interval_counter
  import interval_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/interval_scheduler.sv
// Round-robin time-sharing of one interval counter between two requesters.
// Optional INTERVAL_SCHED_PAUSE_EN adds a pause input that stalls counting.
module interval_scheduler
  import interval_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [CNT_W-1:0] count_out
`ifdef INTERVAL_SCHED_PAUSE_EN
  ,
  input  logic             pause
`endif
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             win_q, win_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             cnt_clear;
  logic             cnt_en;
  logic             stall;
  logic             at_len;
  logic             winner;
  logic [CNT_W-1:0] count;

`ifdef INTERVAL_SCHED_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  // Equality is checked before any increment, so an all-ones length never wraps.
  assign at_len = (count == len_q);
  assign winner = req[ptr_q] ? ptr_q : ~ptr_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    done_d    = done_q;
    len_d     = len_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d     = winner;
          gnt_d     = req_onehot(winner);
          len_d     = (winner == REQ1) ? len1 : len0;
          cnt_clear = 1'b1;
          state_d   = COUNT;
        end
      end
      COUNT: begin
        if (!stall) begin
          if (at_len) begin
            done_d  = gnt_q;
            state_d = DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      DONE: begin
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        cnt_clear = 1'b1;
        ptr_d     = ~win_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= REQ0;
      win_q   <= REQ0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  // The latched length is only consulted in COUNT, which is always entered via a grant.
  always_ff @(posedge clock) begin
    len_q <= len_d;
  end

  interval_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (count)
  );

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign count_out = count;

  a_gnt_onehot0: assert property (@(posedge clock) disable iff (reset) $onehot0(gnt_q));
  a_done_in_gnt: assert property (@(posedge clock) disable iff (reset) ((done_q & ~gnt_q) == 2'b00));

endmodule
